rs232_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares the single RS232 byte transmitter among NREQ byte-stream requesters.
- Sequences the transmitter's start/rdy handshake so that start is never issued while a byte is in flight.
- Supports per-requester lock for atomic multi-byte messages, with a timeout that forces lock release.
- Sits between the CPU-side I/O ports/debug sources and the transmitter in the SoC I/O block.

---
 rtl/soc_io_pkg.sv | 11 +
 rtl/rr_pick.sv | 34 +++
 rtl/rs232_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_rs232_tx_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_io_pkg.sv
// Shared SoC I/O definitions: arbiter FSM state encoding and requester limits.
package soc_io_pkg;

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] ISSUE     = 2'd1;
   localparam logic [1:0] WAIT_BUSY = 2'd2;
   localparam logic [1:0] WAIT_DONE = 2'd3;

   localparam int NREQ_MAX = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set mask bit at or after start, wrapping.
module rr_pick #(
   parameter int N = 4,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] mask,
   input  logic [W-1:0] start,
   output logic [W-1:0] winner,
   output logic         any_valid
);

   logic [W:0]   sum;
   logic [W-1:0] idx;

   // Scan from the far end so the candidate closest to start is written last and wins.
   always_comb begin
      winner    = '0;
      any_valid = 1'b0;
      sum       = '0;
      idx       = '0;
      for (int k = N - 1; k >= 0; k--) begin
         sum = {1'b0, start} + (W + 1)'(k);
         if (sum >= (W + 1)'(N)) begin
            sum = sum - (W + 1)'(N);
         end
         idx = sum[W-1:0];
         if (mask[idx]) begin
            winner    = idx;
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// Round-robin arbiter sharing one RS232 byte transmitter among NREQ requesters,
// with per-requester lock for atomic messages and an idle-lock timeout.
module rs232_tx_arbiter
   import soc_io_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int LOCK_TO = 4096,
   parameter int TOW     = 13
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ-1:0]         lock,
   input  logic [8*NREQ-1:0]       data,
   output logic [NREQ-1:0]         ack,
   output logic                    tx_start,
   output logic [7:0]              tx_data,
   input  logic                    tx_rdy,
   output logic [$clog2(NREQ)-1:0] owner,
   output logic                    locked,
   output logic                    busy
);

   localparam int              OW      = $clog2(NREQ);
   localparam logic [OW-1:0]   LAST    = OW'(NREQ - 1);
   localparam logic [TOW-1:0]  TO_LAST = TOW'(LOCK_TO - 1);

   logic [1:0]     state;
   logic [TOW-1:0] to_cnt;
   logic           wb_cnt;

   logic [OW-1:0]  rr_start;
   logic [OW-1:0]  rr_win;
   logic           rr_any;
   logic [7:0]     bytes [NREQ];

   logic           grant;
   logic [OW-1:0]  grant_idx;
   logic           unlock;
   logic           cnt_inc;
   logic           cnt_clr;

   for (genvar i = 0; i < NREQ; i++) begin : g_bytes
      assign bytes[i] = data[8*i +: 8];
   end

   assign rr_start = (owner == LAST) ? '0 : owner + OW'(1);
   assign busy     = (state != IDLE);

   rr_pick #(
      .N (NREQ),
      .W (OW)
   ) u_pick (
      .mask      (req),
      .start     (rr_start),
      .winner    (rr_win),
      .any_valid (rr_any)
   );

   // IDLE decision: locked owner first, otherwise round-robin after the last owner.
   always_comb begin
      grant     = 1'b0;
      grant_idx = rr_win;
      unlock    = 1'b0;
      cnt_inc   = 1'b0;
      cnt_clr   = 1'b0;
      if (locked) begin
         if (req[owner]) begin
            grant     = tx_rdy;
            grant_idx = owner;
            cnt_clr   = 1'b1;
         end else if (!lock[owner]) begin
            unlock  = 1'b1;
            cnt_clr = 1'b1;
            grant   = tx_rdy && rr_any;
         end else if (LOCK_TO != 0) begin
            if (to_cnt == TO_LAST) begin
               unlock  = 1'b1;
               cnt_clr = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
      end else begin
         grant = tx_rdy && rr_any;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         ack      <= '0;
         tx_start <= 1'b0;
         tx_data  <= '0;
         owner    <= LAST;
         locked   <= 1'b0;
         to_cnt   <= '0;
         wb_cnt   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (unlock) begin
                  locked <= 1'b0;
               end
               if (cnt_clr) begin
                  to_cnt <= '0;
               end else if (cnt_inc) begin
                  to_cnt <= to_cnt + TOW'(1);
               end
               if (grant) begin
                  state    <= ISSUE;
                  owner    <= grant_idx;
                  tx_data  <= bytes[grant_idx];
                  tx_start <= 1'b1;
                  ack      <= NREQ'(1) << grant_idx;
               end
            end
            ISSUE: begin
               tx_start <= 1'b0;
               ack      <= '0;
               locked   <= lock[owner];
               wb_cnt   <= 1'b0;
               state    <= WAIT_BUSY;
            end
            // A transmitter that never drops rdy is abandoned after two cycles.
            WAIT_BUSY: begin
               if (!tx_rdy) begin
                  state <= WAIT_DONE;
               end else if (wb_cnt) begin
                  state <= IDLE;
               end else begin
                  wb_cnt <= 1'b1;
               end
            end
            WAIT_DONE: begin
               if (tx_rdy) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Bench for rs232_tx_arbiter: byte streams per requester, a simple transmitter
// model, and a round-robin/lock reference computed from the stream contents.
module tb_rs232_tx_arbiter;

   localparam int NREQ    = 4;
   localparam int LOCK_TO = 8;
   localparam int TOW     = 13;
   localparam int MAXB    = 16;
   localparam int MAXO    = 2048;

   logic                clk  = 1'b0;
   logic                rst  = 1'b1;
   logic [NREQ-1:0]     req  = '0;
   logic [NREQ-1:0]     lock = '0;
   logic [8*NREQ-1:0]   data = '0;
   logic [NREQ-1:0]     ack;
   logic                tx_start;
   logic [7:0]          tx_data;
   logic                tx_rdy;
   logic [1:0]          owner;
   logic                locked;
   logic                busy;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   int busy_len = 10;
   bit stuck    = 1'b0;
   bit xmt_clr  = 1'b0;
   int tx_left  = 0;

   logic [7:0] stim [NREQ][MAXB];
   int         len  [NREQ];
   int         head [NREQ];
   bit         lockmsg [NREQ];

   int         obs_n = 0;
   int         obs_idx    [MAXO];
   logic [7:0] obs_data   [MAXO];
   int         obs_cyc    [MAXO];
   logic       obs_locked [MAXO];
   int         viol = 0;
   int         last_start = -100;
   int         obs_base = 0;
   int         viol_base = 0;

   int         exp_n;
   int         exp_idx    [64];
   logic [7:0] exp_data   [64];
   logic       exp_locked [64];

   rs232_tx_arbiter #(
      .NREQ    (NREQ),
      .LOCK_TO (LOCK_TO),
      .TOW     (TOW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .lock     (lock),
      .data     (data),
      .ack      (ack),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_rdy   (tx_rdy),
      .owner    (owner),
      .locked   (locked),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Transmitter: goes busy for busy_len cycles after each start (unless stuck).
   always @(posedge clk) begin
      if (xmt_clr) tx_left <= 0;
      else if (tx_start && !stuck) tx_left <= busy_len;
      else if (tx_left > 0) tx_left <= tx_left - 1;
   end
   assign tx_rdy = (tx_left == 0);

   // Protocol monitor and grant recorder.
   always @(negedge clk) begin
      if (!rst) begin
         last_start = -100;
      end else if (tx_start) begin
         if (!tx_rdy) viol++;
         if (ack != (NREQ'(1) << owner)) viol++;
         if (cyc - last_start < 4) viol++;
         last_start = cyc;
         if (obs_n < MAXO) begin
            obs_idx[obs_n]    = int'(owner);
            obs_data[obs_n]   = tx_data;
            obs_cyc[obs_n]    = cyc;
            obs_locked[obs_n] = locked;
            obs_n++;
         end
      end else if (ack != '0) begin
         viol++;
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst     = 1'b0;
      xmt_clr = 1'b1;
      req     = '0;
      lock    = '0;
      data    = '0;
      stuck   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         len[i] = 0; head[i] = 0; lockmsg[i] = 1'b0;
      end
      repeat (2) tick();
      rst       = 1'b1;
      xmt_clr   = 1'b0;
      obs_base  = obs_n;
      viol_base = viol;
   endtask

   task automatic apply_req();
      for (int i = 0; i < NREQ; i++) begin
         if (head[i] < len[i]) begin
            req[i]        = 1'b1;
            lock[i]       = lockmsg[i];
            data[8*i +: 8] = stim[i][head[i]];
         end else begin
            req[i]  = 1'b0;
            lock[i] = 1'b0;
         end
      end
   endtask

   function automatic bit all_done();
      for (int i = 0; i < NREQ; i++) if (head[i] < len[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drive_queues(input int max_cycles, output bit timed_out);
      timed_out = 1'b1;
      apply_req();
      for (int n = 0; n < max_cycles; n++) begin
         tick();
         for (int i = 0; i < NREQ; i++) if (ack[i]) head[i]++;
         apply_req();
         if (all_done() && !busy && tx_rdy) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   // Reference: each grant goes to the first pending stream after the last owner,
   // except that a locking stream with bytes left keeps the transmitter.
   task automatic build_expect();
      int pend [NREQ];
      int pos  [NREQ];
      int last;
      int nxt;
      bit stick;
      last  = NREQ - 1;
      stick = 1'b0;
      exp_n = 0;
      for (int i = 0; i < NREQ; i++) begin pend[i] = len[i]; pos[i] = 0; end
      while (exp_n < 64) begin
         nxt = -1;
         if (stick) nxt = last;
         else begin
            for (int k = 1; k <= NREQ; k++) begin
               if (pend[(last + k) % NREQ] > 0) begin
                  nxt = (last + k) % NREQ;
                  break;
               end
            end
         end
         if (nxt < 0) break;
         exp_idx[exp_n]    = nxt;
         exp_data[exp_n]   = stim[nxt][pos[nxt]];
         exp_locked[exp_n] = stick;
         exp_n++;
         pos[nxt]++;
         pend[nxt]--;
         stick = lockmsg[nxt] && (pend[nxt] > 0);
         last  = nxt;
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b0;
      #2;
      tests++; if (ack !== 4'b0000) begin fails++; $display("FAIL reset_ack: got %b expected 0000", ack); end
      tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
      tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
      tests++; if (owner !== 2'd3) begin fails++; $display("FAIL reset_owner: got %0d expected 3", owner); end
      tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b expected 0", locked); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
      repeat (2) tick();
      rst       = 1'b1;
      obs_base  = obs_n;
      viol_base = viol;
   endtask

   task automatic test_single();
      bit to;
      do_reset();
      busy_len = 10;
      len[0] = 2; stim[0][0] = 8'h55; stim[0][1] = 8'h66;
      drive_queues(200, to);
      tests++; if (to) begin fails++; $display("FAIL single_timeout: got timeout expected completion"); end
      tests++; if (obs_n - obs_base != 2) begin fails++; $display("FAIL single_count: got %0d expected 2", obs_n - obs_base); end
      tests++; if (obs_idx[obs_base] != 0 || obs_data[obs_base] !== 8'h55) begin fails++;
         $display("FAIL single_first: got req %0d data %h expected req 0 data 55", obs_idx[obs_base], obs_data[obs_base]); end
      tests++; if (obs_data[obs_base+1] !== 8'h66) begin fails++; $display("FAIL single_second: got %h expected 66", obs_data[obs_base+1]); end
      tests++; if (obs_cyc[obs_base+1] - obs_cyc[obs_base] != busy_len + 3) begin fails++;
         $display("FAIL single_spacing: got %0d expected %0d", obs_cyc[obs_base+1] - obs_cyc[obs_base], busy_len + 3); end
      tests++; if (viol != viol_base) begin fails++; $display("FAIL single_protocol: got %0d violations expected 0", viol - viol_base); end
   endtask

   task automatic test_round_robin();
      bit to;
      do_reset();
      busy_len = 6;
      for (int i = 0; i < NREQ; i++) begin len[i] = 1; stim[i][0] = 8'hA0 + 8'(i); end
      len[0] = 2; stim[0][1] = 8'hA4;
      build_expect();
      drive_queues(300, to);
      tests++; if (to) begin fails++; $display("FAIL rr_timeout: got timeout expected completion"); end
      tests++; if (obs_n - obs_base != exp_n) begin fails++; $display("FAIL rr_count: got %0d expected %0d", obs_n - obs_base, exp_n); end
      for (int k = 0; k < exp_n; k++) begin
         tests++; if (obs_idx[obs_base+k] != exp_idx[k] || obs_data[obs_base+k] !== exp_data[k]) begin fails++;
            $display("FAIL rr_grant%0d: got req %0d data %h expected req %0d data %h", k,
                     obs_idx[obs_base+k], obs_data[obs_base+k], exp_idx[k], exp_data[k]); end
      end
      tests++; if (viol != viol_base) begin fails++; $display("FAIL rr_protocol: got %0d violations expected 0", viol - viol_base); end
   endtask

   task automatic test_lock();
      bit to;
      do_reset();
      busy_len = 5;
      len[0] = 3; lockmsg[0] = 1'b1;
      stim[0][0] = 8'h10; stim[0][1] = 8'h11; stim[0][2] = 8'h12;
      len[1] = 2; stim[1][0] = 8'h20; stim[1][1] = 8'h21;
      build_expect();
      drive_queues(300, to);
      tests++; if (to) begin fails++; $display("FAIL lock_timeout: got timeout expected completion"); end
      tests++; if (obs_n - obs_base != exp_n) begin fails++; $display("FAIL lock_count: got %0d expected %0d", obs_n - obs_base, exp_n); end
      for (int k = 0; k < exp_n; k++) begin
         tests++; if (obs_idx[obs_base+k] != exp_idx[k] || obs_data[obs_base+k] !== exp_data[k] ||
                      obs_locked[obs_base+k] !== exp_locked[k]) begin fails++;
            $display("FAIL lock_grant%0d: got req %0d data %h locked %b expected req %0d data %h locked %b", k,
                     obs_idx[obs_base+k], obs_data[obs_base+k], obs_locked[obs_base+k],
                     exp_idx[k], exp_data[k], exp_locked[k]); end
      end
   endtask

   task automatic test_lock_timeout();
      bit seen;
      do_reset();
      busy_len = 6;
      req[2] = 1'b1; lock[2] = 1'b1; data[23:16] = 8'h77;
      seen = 1'b0;
      for (int n = 0; n < 30; n++) begin tick(); if (tx_start) begin seen = 1'b1; break; end end
      tests++; if (!seen) begin fails++; $display("FAIL to_first_grant: got no start expected start within 30 cycles"); end
      req[2] = 1'b0; req[3] = 1'b1; data[31:24] = 8'h88;
      repeat (12) tick();
      tests++; if (locked !== 1'b1 || busy !== 1'b0) begin fails++;
         $display("FAIL to_stall: got locked %b busy %b expected locked 1 busy 0", locked, busy); end
      seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (obs_n - obs_base >= 2) begin seen = 1'b1; break; end
         tick();
      end
      tests++; if (!seen) begin fails++; $display("FAIL to_second_grant: got no start expected start within 40 cycles"); end
      tests++; if (obs_idx[obs_base+1] != 3 || obs_data[obs_base+1] !== 8'h88 || obs_locked[obs_base+1] !== 1'b0) begin fails++;
         $display("FAIL to_winner: got req %0d data %h locked %b expected req 3 data 88 locked 0",
                  obs_idx[obs_base+1], obs_data[obs_base+1], obs_locked[obs_base+1]); end
      tests++; if (obs_cyc[obs_base+1] - obs_cyc[obs_base] != busy_len + 11) begin fails++;
         $display("FAIL to_latency: got %0d expected %0d", obs_cyc[obs_base+1] - obs_cyc[obs_base], busy_len + 11); end
      req = '0; lock = '0;
   endtask

   task automatic test_reset_mid();
      bit seen;
      do_reset();
      busy_len = 10;
      req[1] = 1'b1; data[15:8] = 8'h44;
      seen = 1'b0;
      for (int n = 0; n < 30; n++) begin tick(); if (tx_start) begin seen = 1'b1; break; end end
      tests++; if (!seen) begin fails++; $display("FAIL mid_first_grant: got no start expected start within 30 cycles"); end
      req[1] = 1'b0;
      repeat (4) tick();
      tests++; if (busy !== 1'b1 || tx_rdy !== 1'b0) begin fails++;
         $display("FAIL mid_inflight: got busy %b rdy %b expected busy 1 rdy 0", busy, tx_rdy); end
      #3 rst = 1'b0;
      #1;
      tests++; if (ack !== 4'b0000 || tx_start !== 1'b0 || owner !== 2'd3 || busy !== 1'b0 || locked !== 1'b0) begin fails++;
         $display("FAIL mid_async_reset: got ack %b start %b owner %0d busy %b locked %b expected 0000 0 3 0 0",
                  ack, tx_start, owner, busy, locked); end
      req[0] = 1'b1; data[7:0] = 8'h5A;
      req[2] = 1'b1; data[23:16] = 8'h6B;
      tick();
      rst = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (obs_n - obs_base >= 2) begin seen = 1'b1; break; end
         tick();
      end
      tests++; if (!seen || obs_idx[obs_base+1] != 0 || obs_data[obs_base+1] !== 8'h5A) begin fails++;
         $display("FAIL mid_next_grant: got seen %b req %0d data %h expected req 0 data 5a",
                  seen, obs_idx[obs_base+1], obs_data[obs_base+1]); end
      tests++; if (viol != viol_base) begin fails++; $display("FAIL mid_protocol: got %0d violations expected 0", viol - viol_base); end
      req = '0;
   endtask

   task automatic test_stuck_rdy();
      bit to;
      do_reset();
      stuck = 1'b1;
      len[0] = 2; stim[0][0] = 8'h31; stim[0][1] = 8'h32;
      drive_queues(100, to);
      tests++; if (to || obs_n - obs_base != 2) begin fails++;
         $display("FAIL stuck_count: got timeout %b starts %0d expected timeout 0 starts 2", to, obs_n - obs_base); end
      tests++; if (obs_cyc[obs_base+1] - obs_cyc[obs_base] != 4 || obs_data[obs_base+1] !== 8'h32) begin fails++;
         $display("FAIL stuck_recover: got spacing %0d data %h expected spacing 4 data 32",
                  obs_cyc[obs_base+1] - obs_cyc[obs_base], obs_data[obs_base+1]); end
   endtask

   task automatic test_random();
      bit to;
      for (int it = 0; it < 12; it++) begin
         do_reset();
         busy_len = $urandom_range(1, 12);
         for (int i = 0; i < NREQ; i++) begin
            len[i]     = $urandom_range(0, 5);
            lockmsg[i] = 1'($urandom_range(0, 1));
            for (int b = 0; b < MAXB; b++) stim[i][b] = 8'($urandom);
         end
         build_expect();
         drive_queues(3000, to);
         tests++; if (to || obs_n - obs_base != exp_n) begin fails++;
            $display("FAIL rand%0d_count: got timeout %b starts %0d expected timeout 0 starts %0d", it, to, obs_n - obs_base, exp_n); end
         for (int k = 0; k < exp_n; k++) begin
            tests++; if (obs_idx[obs_base+k] != exp_idx[k] || obs_data[obs_base+k] !== exp_data[k] ||
                         obs_locked[obs_base+k] !== exp_locked[k]) begin fails++;
               $display("FAIL rand%0d_grant%0d: got req %0d data %h locked %b expected req %0d data %h locked %b", it, k,
                        obs_idx[obs_base+k], obs_data[obs_base+k], obs_locked[obs_base+k],
                        exp_idx[k], exp_data[k], exp_locked[k]); end
         end
         tests++; if (viol != viol_base) begin fails++;
            $display("FAIL rand%0d_protocol: got %0d violations expected 0", it, viol - viol_base); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_lock();
      test_lock_timeout();
      test_reset_mid();
      test_stuck_rdy();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
